// File: rtl/cam_power_sequencer.sv
// rtl/cam_power_sequencer.sv - image sensor power-up, reset, configuration and shutdown sequencer
// Optional feature macro CAM_XMASTER_EN: latch xmaster_sel_i onto cam_xmaster_o for each power-up.
module cam_power_sequencer #(
  parameter int DEBOUNCE_CYCLES    = 1024,
  parameter int RAIL_DELAY_CYCLES  = 4096,
  parameter int PG_TIMEOUT_CYCLES  = 32768,
  parameter int RESET_HOLD_CYCLES  = 8192,
  parameter int CFG_TIMEOUT_CYCLES = 65535,
  parameter int CNT_W              = 17
) (
  input  logic       sclk_i,
  input  logic       reset_n_i,
  input  logic       cam_ctrl_in,
  input  logic [2:0] pg_i,
  input  logic       xmaster_sel_i,
  input  logic       cfg_done_i,
  input  logic       cfg_err_i,
  output logic [2:0] rail_en_o,
  output logic       cam_reset_o,
  output logic       cam_xmaster_o,
  output logic       cfg_start_o,
  output logic       stream_en_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_RAIL_UP  = 3'd1;
  localparam logic [2:0] S_RST_HOLD = 3'd2;
  localparam logic [2:0] S_CFG      = 3'd3;
  localparam logic [2:0] S_RUN      = 3'd4;
  localparam logic [2:0] S_RAIL_DN  = 3'd5;
  localparam logic [2:0] S_FAULT    = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RAIL_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PG_LAST  = CNT_W'(PG_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RH_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CFG_TIMEOUT_CYCLES - 1);

  logic             ctrl_s1_q, ctrl_s2_q;
  logic [2:0]       pg_s1_q, pg_s2_q;
  logic             ctrl_db_q, ctrl_db_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  logic [2:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rail_en_q, rail_en_d, dn_rails;
  logic             cam_reset_q, cam_reset_d;
  logic             cfg_start_q, cfg_start_d;
  logic             stream_en_q, stream_en_d;
  logic             fault_q, fault_d;
  logic             pg_idx;

  assign pg_idx = pg_s2_q[idx_q];

  // Debounce counts consecutive samples that disagree with the accepted level.
  always_comb begin
    ctrl_db_d = ctrl_db_q;
    db_cnt_d  = '0;
    if (ctrl_s2_q != ctrl_db_q) begin
      if (db_cnt_q >= DB_LAST) ctrl_db_d = ctrl_s2_q;
      else                     db_cnt_d  = db_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_ONE;
    dn_rails = rail_en_q >> 1;
    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        idx_d = 2'd0;
        if (ctrl_db_q) state_d = S_RAIL_UP;
      end
      S_RAIL_UP: begin
        if (!pg_idx && cnt_q >= PG_LAST) state_d = S_FAULT;
        else if (!ctrl_db_q)             state_d = S_RAIL_DN;
        else if (pg_idx && cnt_q >= RD_LAST) begin
          cnt_d = '0;
          if (idx_q == 2'd2) state_d = S_RST_HOLD;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      S_RST_HOLD: begin
        if (!ctrl_db_q)            state_d = S_RAIL_DN;
        else if (cnt_q >= RH_LAST) state_d = S_CFG;
      end
      S_CFG: begin
        if (cfg_err_i)                         state_d = S_FAULT;
        else if (!cfg_done_i && cnt_q >= CFG_LAST) state_d = S_FAULT;
        else if (!ctrl_db_q)                   state_d = S_RAIL_DN;
        else if (cfg_done_i)                   state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = '0;
        if (pg_s2_q != 3'b111) state_d = S_FAULT;
        else if (!ctrl_db_q)   state_d = S_RAIL_DN;
      end
      S_RAIL_DN: begin
        // Rails are always a contiguous run from bit 0, so a right shift drops the highest one.
        if (cnt_q >= RD_LAST) begin
          cnt_d = '0;
          if (rail_en_q == 3'b000) state_d = S_OFF;
        end else begin
          dn_rails = rail_en_q;
        end
      end
      S_FAULT: begin
        cnt_d = '0;
        if (!ctrl_db_q) state_d = S_OFF;
      end
      default: state_d = S_FAULT;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    rail_en_d = 3'b000;
    case (state_d)
      S_RAIL_UP:                 rail_en_d = (idx_d == 2'd0) ? 3'b001 :
                                             (idx_d == 2'd1) ? 3'b011 : 3'b111;
      S_RST_HOLD, S_CFG, S_RUN:  rail_en_d = 3'b111;
      S_RAIL_DN:                 rail_en_d = dn_rails;
      default:                   rail_en_d = 3'b000;
    endcase
    cam_reset_d = !(state_d == S_CFG || state_d == S_RUN);
    cfg_start_d = (state_d == S_CFG) && (state_q != S_CFG);
    stream_en_d = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge sclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_s1_q   <= 1'b0;
      ctrl_s2_q   <= 1'b0;
      pg_s1_q     <= 3'b000;
      pg_s2_q     <= 3'b000;
      ctrl_db_q   <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= S_OFF;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      rail_en_q   <= 3'b000;
      cam_reset_q <= 1'b1;
      cfg_start_q <= 1'b0;
      stream_en_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      ctrl_s1_q   <= cam_ctrl_in;
      ctrl_s2_q   <= ctrl_s1_q;
      pg_s1_q     <= pg_i;
      pg_s2_q     <= pg_s1_q;
      ctrl_db_q   <= ctrl_db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rail_en_q   <= rail_en_d;
      cam_reset_q <= cam_reset_d;
      cfg_start_q <= cfg_start_d;
      stream_en_q <= stream_en_d;
      fault_q     <= fault_d;
    end
  end

`ifdef CAM_XMASTER_EN
  logic xmaster_q, xmaster_d;

  always_comb begin
    xmaster_d = xmaster_q;
    if (state_d == S_OFF)      xmaster_d = 1'b0;
    else if (state_q == S_OFF) xmaster_d = xmaster_sel_i;
  end

  always_ff @(posedge sclk_i or negedge reset_n_i) begin
    if (!reset_n_i) xmaster_q <= 1'b0;
    else            xmaster_q <= xmaster_d;
  end

  assign cam_xmaster_o = xmaster_q;
`else
  logic unused_xmaster_sel;
  assign unused_xmaster_sel = xmaster_sel_i;
  assign cam_xmaster_o      = 1'b0;
`endif

  assign rail_en_o   = rail_en_q;
  assign cam_reset_o = cam_reset_q;
  assign cfg_start_o = cfg_start_q;
  assign stream_en_o = stream_en_q;
  assign fault_o     = fault_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cam_power_sequencer.sv
// tb/tb_cam_power_sequencer.sv - self-checking bench for cam_power_sequencer
// Expected outputs come from event timelines computed from the sequencing rules; honours CAM_XMASTER_EN.
module tb_cam_power_sequencer;

  localparam int DB  = 4;
  localparam int RD  = 8;
  localparam int PGT = 32;
  localparam int RH  = 16;
  localparam int CT  = 64;

  logic       sclk_i = 1'b0;
  logic       reset_n_i;
  logic       cam_ctrl_in;
  logic [2:0] pg_i;
  logic       xmaster_sel_i;
  logic       cfg_done_i;
  logic       cfg_err_i;
  logic [2:0] rail_en_o;
  logic       cam_reset_o;
  logic       cam_xmaster_o;
  logic       cfg_start_o;
  logic       stream_en_o;
  logic       fault_o;
  logic [2:0] state_o;

  always #5 sclk_i = ~sclk_i;

  cam_power_sequencer #(
    .DEBOUNCE_CYCLES(DB), .RAIL_DELAY_CYCLES(RD), .PG_TIMEOUT_CYCLES(PGT),
    .RESET_HOLD_CYCLES(RH), .CFG_TIMEOUT_CYCLES(CT), .CNT_W(17)
  ) dut (
    .sclk_i(sclk_i), .reset_n_i(reset_n_i), .cam_ctrl_in(cam_ctrl_in), .pg_i(pg_i),
    .xmaster_sel_i(xmaster_sel_i), .cfg_done_i(cfg_done_i), .cfg_err_i(cfg_err_i),
    .rail_en_o(rail_en_o), .cam_reset_o(cam_reset_o), .cam_xmaster_o(cam_xmaster_o),
    .cfg_start_o(cfg_start_o), .stream_en_o(stream_en_o), .fault_o(fault_o), .state_o(state_o)
  );

  typedef struct { int t; int v; } ev_t;
  typedef struct { int t; int ch; int v; } in_t;

  ev_t st_q[$];
  ev_t rl_q[$];
  ev_t xm_q[$];
  in_t in_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  function automatic int last_val(input ev_t q[$], input int c);
    int best_t;
    int v;
    best_t = -1;
    v      = 0;
    foreach (q[i]) begin
      if (q[i].t <= c && q[i].t >= best_t) begin
        best_t = q[i].t;
        v      = q[i].v;
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] b32(input logic x);
    return {31'b0, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic ev_st(input int tt, input int vv); st_q.push_back('{tt, vv}); endtask
  task automatic ev_rl(input int tt, input int vv); rl_q.push_back('{tt, vv}); endtask
  task automatic ev_xm(input int tt, input int vv); xm_q.push_back('{tt, vv}); endtask
  task automatic sched(input int tt, input int ch, input int vv); in_q.push_back('{tt, ch, vv}); endtask

  // One clock: sample just after the edge, compare against the timelines, then drive this cycle's inputs.
  task automatic step();
    int s, sp, xm;
    @(posedge sclk_i);
    #1;
    cyc++;
    s  = last_val(st_q, cyc);
    sp = last_val(st_q, cyc - 1);
`ifdef CAM_XMASTER_EN
    xm = last_val(xm_q, cyc);
`else
    xm = 0;
`endif
    check("state",     32'(state_o),   32'(s));
    check("rail_en",   32'(rail_en_o), 32'(last_val(rl_q, cyc)));
    check("cam_reset", b32(cam_reset_o), b32(!(s == 3 || s == 4)));
    check("stream_en", b32(stream_en_o), b32(s == 4));
    check("fault",     b32(fault_o),     b32(s == 6));
    check("cfg_start", b32(cfg_start_o), b32(s == 3 && sp != 3));
    check("xmaster",   b32(cam_xmaster_o), 32'(xm));
    cfg_done_i = 1'b0;
    cfg_err_i  = 1'b0;
    foreach (in_q[i]) begin
      if (in_q[i].t == cyc) begin
        case (in_q[i].ch)
          0:       cam_ctrl_in = (in_q[i].v != 0);
          1, 2, 3: pg_i[in_q[i].ch - 1] = (in_q[i].v != 0);
          4:       xmaster_sel_i = (in_q[i].v != 0);
          5:       cfg_done_i = 1'b1;
          default: cfg_err_i = 1'b1;
        endcase
      end
    end
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step();
  endtask

  // mode 0: cfg_done -> RUN; 1: cfg_done+cfg_err together; 2: cfg timeout; 3: pg[1] never rises
  task automatic bring_up(input int d0, input int d1, input int d2, input int e, input int mode, input logic sel);
    int d[3];
    int t0, tk, r;
    d[0] = d0; d[1] = d1; d[2] = d2;
    t0 = cyc + 1;
    sched(t0, 0, 1);
    sched(t0, 4, int'(sel));
    tk = t0 + 3 + DB;
    ev_st(tk, 1);
    ev_xm(tk, int'(sel));
    sched(tk + 1, 4, int'(!sel));
    for (int k = 0; k < 3; k++) begin
      ev_rl(tk, (1 << (k + 1)) - 1);
      if (mode == 3 && k == 1) begin
        ev_st(tk + PGT, 6);
        ev_rl(tk + PGT, 0);
        run_until(tk + PGT + 4);
        return;
      end
      sched(tk + d[k], 1 + k, 1);
      tk = tk + ((d[k] + 3 > RD) ? d[k] + 3 : RD);
    end
    ev_st(tk, 2);
    r = tk + RH;
    ev_st(r, 3);
    case (mode)
      0: begin
        sched(r + e, 5, 1);
        ev_st(r + e + 1, 4);
        run_until(r + e + 4);
      end
      1: begin
        sched(r + e, 5, 1);
        sched(r + e, 6, 1);
        ev_st(r + e + 1, 6);
        ev_rl(r + e + 1, 0);
        run_until(r + e + 4);
      end
      default: begin
        ev_st(r + CT, 6);
        ev_rl(r + CT, 0);
        run_until(r + CT + 3);
      end
    endcase
  endtask

  task automatic power_off_from_fault();
    int t2, o;
    t2 = cyc + 1;
    sched(t2, 0, 0);
    o = t2 + 3 + DB;
    ev_st(o, 0);
    ev_xm(o, 0);
    for (int k = 0; k < 3; k++) sched(o, 1 + k, 0);
    run_until(o + 3);
  endtask

  // Ctrl drops from RUN; a second accepted ctrl pulse mid-sequence must not abort it.
  task automatic shut_down();
    int t1, d0;
    t1 = cyc + 1;
    sched(t1, 0, 0);
    d0 = t1 + 3 + DB;
    sched(d0 + 2, 0, 1);
    sched(d0 + 10, 0, 0);
    ev_st(d0, 5);
    ev_rl(d0, 3);
    ev_rl(d0 + RD, 1);
    ev_rl(d0 + 2 * RD, 0);
    ev_st(d0 + 3 * RD, 0);
    ev_xm(d0 + 3 * RD, 0);
    for (int k = 0; k < 3; k++) sched(d0 + 3 * RD, 1 + k, 0);
    run_until(d0 + 3 * RD + 3);
  endtask

  task automatic pg_drop(input int bit_i, input int gap);
    int p;
    p = cyc + 1 + gap;
    sched(p, 1 + bit_i, 0);
    ev_st(p + 3, 6);
    ev_rl(p + 3, 0);
    run_until(p + 6);
  endtask

  task automatic glitch();
    int t;
    t = cyc + 1;
    sched(t, 0, 1);
    sched(t + 3, 0, 0);
    run_until(t + 15);
  endtask

  task automatic async_reset_check();
    #3;
    reset_n_i = 1'b0;
    #1;
    check("rst_rail_en",   32'(rail_en_o), 32'd0);
    check("rst_state",     32'(state_o),   32'd0);
    check("rst_cam_reset", b32(cam_reset_o), 32'd1);
    check("rst_stream_en", b32(stream_en_o), 32'd0);
    check("rst_fault",     b32(fault_o),     32'd0);
    check("rst_cfg_start", b32(cfg_start_o), 32'd0);
    check("rst_xmaster",   b32(cam_xmaster_o), 32'd0);
    cam_ctrl_in = 1'b0;
    pg_i        = 3'b000;
    ev_st(cyc + 1, 0);
    ev_rl(cyc + 1, 0);
    ev_xm(cyc + 1, 0);
    run_until(cyc + 2);
    reset_n_i = 1'b1;
    run_until(cyc + 4);
  endtask

  initial begin
    int d0, d1, d2, e;
    logic sel;
    reset_n_i     = 1'b0;
    cam_ctrl_in   = 1'b0;
    pg_i          = 3'b000;
    xmaster_sel_i = 1'b0;
    cfg_done_i    = 1'b0;
    cfg_err_i     = 1'b0;
    ev_st(0, 0);
    ev_rl(0, 0);
    ev_xm(0, 0);
    run_until(3);
    reset_n_i = 1'b1;
    run_until(6);

    bring_up(3, 3, 3, 5, 0, 1'b1);
    shut_down();
    glitch();
    bring_up(2, 0, 0, 0, 3, 1'b1);
    power_off_from_fault();
    bring_up(3, 3, 3, 5, 1, 1'b0);
    power_off_from_fault();
    bring_up(29, 12, 0, 3, 0, 1'b1);
    async_reset_check();

    for (int i = 0; i < 6; i++) begin
      d0  = int'($urandom_range(0, 12));
      d1  = int'($urandom_range(0, 12));
      d2  = int'($urandom_range(0, 12));
      e   = int'($urandom_range(0, 20));
      sel = 1'($urandom_range(0, 1));
      bring_up(d0, d1, d2, e, 0, sel);
      if ($urandom_range(0, 1) == 0) begin
        shut_down();
      end else begin
        pg_drop(int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
        power_off_from_fault();
      end
    end

    bring_up(4, 1, 7, 0, 2, 1'b1);
    power_off_from_fault();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_power_sequencer.md
# cam_power_sequencer

Sequences power-up, reset release, configuration hand-off and power-down of the image sensor from a single host enable line. Sits between the host control input and the sensor's rail enables, reset and master/slave strap, running on the slow system clock (never a MIPI/camera-derived clock). Supervises rail power-good and the configuration engine, and forces a safe shutdown on any fault.

## Interface
- DEBOUNCE_CYCLES, 1024: cycles cam_ctrl_in must be stable before it is accepted
- RAIL_DELAY_CYCLES, 4096: minimum dwell between successive rail enables or disables
- PG_TIMEOUT_CYCLES, 32768: maximum wait for a rail's power-good, measured from its enable
- RESET_HOLD_CYCLES, 8192: cycles cam_reset_o stays asserted after the last rail is good
- CFG_TIMEOUT_CYCLES, 65535: maximum wait for cfg_done_i
- CNT_W, 17: shared counter width; must hold the largest parameter
- sclk_i  in  1  slow system clock
- reset_n_i  in  1  asynchronous active-low reset
- cam_ctrl_in  in  1  host power request, asynchronous
- pg_i  in  3  rail power-good [0]=analog, [1]=core, [2]=IO; asynchronous
- xmaster_sel_i  in  1  requested master(1)/slave(0) mode
- cfg_done_i  in  1  configuration engine finished, 1-cycle pulse
- cfg_err_i  in  1  configuration engine error, 1-cycle pulse
- rail_en_o  out  3  rail enables
- cam_reset_o  out  1  sensor reset, active-high (1 = held in reset)
- cam_xmaster_o  out  1  sensor master/slave strap
- cfg_start_o  out  1  1-cycle pulse that starts sensor configuration
- stream_en_o  out  1  downstream capture enable
- fault_o  out  1  sticky fault flag
- state_o  out  3  current state encoding, for debug

## Operation
- cam_ctrl_in and pg_i each pass through 2-FF synchronisers.
- The synchronised ctrl is debounced: ctrl_db updates only after DEBOUNCE_CYCLES consecutive equal samples. ctrl_db resets to 0.
- FSM states and encodings: OFF=0, RAIL_UP=1, RST_HOLD=2, CFG=3, RUN=4, RAIL_DN=5, FAULT=6.
- OFF: rail_en_o=0, cam_reset_o=1, all other outputs 0. When ctrl_db=1, go to RAIL_UP with idx=0 and cnt=0.
- RAIL_UP:
  - rail_en_o[idx:0]=1.
  - Advance when pg[idx]=1 and cnt≥RAIL_DELAY_CYCLES-1; on advance idx increments and cnt clears.
  - After idx=2 advances, go to RST_HOLD.
  - If cnt reaches PG_TIMEOUT_CYCLES-1 without pg[idx], go to FAULT.
- RST_HOLD: cam_reset_o=1 for RESET_HOLD_CYCLES, then deassert and go to CFG. cfg_start_o pulses in the first CFG cycle.
- CFG:
  - cfg_done_i → RUN.
  - cfg_err_i → FAULT. cfg_err_i wins if it arrives in the same cycle as cfg_done_i.
  - cnt reaching CFG_TIMEOUT_CYCLES-1 → FAULT.
- RUN: stream_en_o=1. Any pg bit low → FAULT.
- ctrl_db=0 in RAIL_UP, RST_HOLD, CFG or RUN → RAIL_DN.
  - The fault checks in the current state take priority over this.
- RAIL_DN:
  - On entry, stream_en_o=0 and cam_reset_o=1 immediately.
  - Enabled rails turn off in reverse order (2, 1, 0), one per RAIL_DELAY_CYCLES; the first disable happens on entry.
  - After rail 0 is off, dwell RAIL_DELAY_CYCLES, then go to OFF.
  - ctrl_db returning to 1 does not abort the sequence.
- FAULT:
  - All rails off in the same cycle, cam_reset_o=1, stream_en_o=0, fault_o=1.
  - Stay until ctrl_db=0, then go to OFF.
  - fault_o clears on entry to OFF.

## Timing
- cam_ctrl_in to a ctrl_db change: 2 + DEBOUNCE_CYCLES cycles.
- ctrl_db=1 to rail_en_o[0]=1: 1 cycle (OFF→RAIL_UP).
- Rail k+1 enables no earlier than RAIL_DELAY_CYCLES after rail k, and only once pg[k] is seen (pg adds 2-cycle synchroniser latency).
- The last rail advance to cam_reset_o=0 is exactly RESET_HOLD_CYCLES.
- cfg_done_i to stream_en_o=1: 1 cycle.
- A pg drop in RUN to rail_en_o=0: 3 cycles (2 sync + 1).
- All outputs are registered.
- Reset mid-operation: all registers asynchronously return to the OFF values, including cam_reset_o=1 and rail_en_o=0.

## Configuration
- CAM_XMASTER_EN defined:
  - xmaster_sel_i is sampled on the OFF→RAIL_UP transition and driven on cam_xmaster_o.
  - The value holds until OFF is re-entered; it is 0 in OFF.
- CAM_XMASTER_EN undefined: cam_xmaster_o is tied 0 and xmaster_sel_i is ignored.

## Test plan
All scenarios use DEBOUNCE=4, RAIL_DELAY=8, PG_TIMEOUT=32, RESET_HOLD=16, CFG_TIMEOUT=64.
- Normal bring-up:
  - Stimulus: ctrl high; pg follows each enable after 3 cycles; cfg_done 5 cycles after cfg_start.
  - Response: rails enable at 8-cycle spacing; cam_reset_o falls 16 cycles after rail 2 advances; one cfg_start_o pulse; stream_en_o=1; state_o=4.
- Glitch rejection: a 3-cycle ctrl pulse → state stays OFF; rail_en_o stays 0.
- PG timeout: pg[1] never rises → FAULT 32 cycles after rail 1 enables; rail_en_o=0; fault_o=1 until ctrl low, then OFF with fault_o=0.
- Shutdown from RUN: ctrl low → stream_en_o=0 and cam_reset_o=1 on entry; rail_en_o goes 111→011→001→000 at 8-cycle spacing; OFF 8 cycles later.
- cfg_done and cfg_err in the same cycle → FAULT, not RUN.
- Async reset asserted in RUN → outputs immediately show OFF values. With CAM_XMASTER_EN and xmaster_sel_i=1 at power-up, cam_xmaster_o=1 in RUN and 0 after reset.
